// File: rtl/xcore_bpu_upd_sched.sv
// BIM write-port scheduler: power-on sweep, then commit-first arbitration of two queued requesters.
// Push at edge N, write visible after edge N+1; each requester is backpressured by its own queue-full ready.
module xcore_bpu_upd_sched #(
   parameter int              IDXW       = 10,
   parameter int              DW         = 2,
   parameter logic [DW-1:0]   INIT_VAL   = 2'b01,
   parameter int              FQ_DEPTH   = 4,
   parameter int              CQ_DEPTH   = 4,
   parameter int              STARVE_MAX = 3
) (
   input  logic            i_sys_clk,
   input  logic            i_sys_rst,
   input  logic            i_flush,
   input  logic            i_fe_req,
   input  logic [IDXW-1:0] i_fe_idx,
   input  logic [DW-1:0]   i_fe_data,
   output logic            o_fe_rdy,
   input  logic            i_cmt_req,
   input  logic [IDXW-1:0] i_cmt_idx,
   input  logic [DW-1:0]   i_cmt_data,
   output logic            o_cmt_rdy,
   output logic            o_wr_en,
   output logic [IDXW-1:0] o_wr_idx,
   output logic [DW-1:0]   o_wr_data,
   output logic [1:0]      o_wr_src,
   output logic            o_init_done
);

   localparam int FPW = $clog2(FQ_DEPTH);
   localparam int FCW = FPW + 1;
   localparam int CPW = $clog2(CQ_DEPTH);
   localparam int CCW = CPW + 1;
   localparam int SCW = $clog2(STARVE_MAX + 1);
   localparam int SWW = IDXW + 1;
   localparam int EW  = IDXW + DW;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [SWW-1:0]  sweep_cnt, sweep_nxt;
   logic [EW-1:0]   fe_mem  [FQ_DEPTH];
   logic [EW-1:0]   cmt_mem [CQ_DEPTH];
   logic [FPW-1:0]  fe_rptr, fe_wptr;
   logic [FCW-1:0]  fe_cnt;
   logic [CPW-1:0]  cmt_rptr, cmt_wptr;
   logic [CCW-1:0]  cmt_cnt;
   logic [SCW-1:0]  starve_cnt;
   logic            fe_ne, cmt_ne, starved, run;
   logic            gnt_fe, gnt_cmt, fe_push, cmt_push;
   logic [EW-1:0]   fe_head, cmt_head;
   logic            wr_en_nxt, done_nxt;
   logic [IDXW-1:0] wr_idx_nxt;
   logic [DW-1:0]   wr_data_nxt;
   logic [1:0]      wr_src_nxt;

   assign run       = (state == ST_RUN);
   assign o_fe_rdy  = run && (fe_cnt < FCW'(FQ_DEPTH));
   assign o_cmt_rdy = run && (cmt_cnt < CCW'(CQ_DEPTH));
   assign fe_ne     = (fe_cnt != '0);
   assign cmt_ne    = (cmt_cnt != '0);
   assign starved   = (starve_cnt == SCW'(STARVE_MAX));
   // A flushing frontend is never granted, so commit takes the slot even when starved.
   assign gnt_fe    = run && fe_ne && !i_flush && (!cmt_ne || starved);
   assign gnt_cmt   = run && cmt_ne && !gnt_fe;
   assign fe_push   = i_fe_req && o_fe_rdy && !i_flush;
   assign cmt_push  = i_cmt_req && o_cmt_rdy;
   assign fe_head   = fe_mem[fe_rptr];
   assign cmt_head  = cmt_mem[cmt_rptr];

   always_comb begin
      state_nxt   = state;
      sweep_nxt   = sweep_cnt;
      wr_en_nxt   = 1'b0;
      wr_idx_nxt  = o_wr_idx;
      wr_data_nxt = o_wr_data;
      wr_src_nxt  = o_wr_src;
      done_nxt    = o_init_done;
      case (state)
         ST_INIT: begin
            // The extra counter bit marks the sweep as finished one cycle after the last write.
            if (!sweep_cnt[IDXW]) begin
               wr_en_nxt   = 1'b1;
               wr_idx_nxt  = sweep_cnt[IDXW-1:0];
               wr_data_nxt = INIT_VAL;
               wr_src_nxt  = 2'b00;
               sweep_nxt   = sweep_cnt + SWW'(1);
            end else begin
               state_nxt = ST_RUN;
               done_nxt  = 1'b1;
            end
         end
         ST_RUN: begin
            if (gnt_cmt) begin
               wr_en_nxt   = 1'b1;
               wr_idx_nxt  = cmt_head[EW-1:DW];
               wr_data_nxt = cmt_head[DW-1:0];
               wr_src_nxt  = 2'b10;
            end else if (gnt_fe) begin
               wr_en_nxt   = 1'b1;
               wr_idx_nxt  = fe_head[EW-1:DW];
               wr_data_nxt = fe_head[DW-1:0];
               wr_src_nxt  = 2'b01;
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (fe_push)  fe_mem[fe_wptr]   <= {i_fe_idx, i_fe_data};
      if (cmt_push) cmt_mem[cmt_wptr] <= {i_cmt_idx, i_cmt_data};
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst) begin
         state       <= ST_INIT;
         sweep_cnt   <= '0;
         o_wr_en     <= 1'b0;
         o_wr_idx    <= '0;
         o_wr_data   <= '0;
         o_wr_src    <= 2'b00;
         o_init_done <= 1'b0;
         fe_rptr     <= '0;
         fe_wptr     <= '0;
         fe_cnt      <= '0;
         cmt_rptr    <= '0;
         cmt_wptr    <= '0;
         cmt_cnt     <= '0;
         starve_cnt  <= '0;
      end else begin
         state       <= state_nxt;
         sweep_cnt   <= sweep_nxt;
         o_wr_en     <= wr_en_nxt;
         o_wr_idx    <= wr_idx_nxt;
         o_wr_data   <= wr_data_nxt;
         o_wr_src    <= wr_src_nxt;
         o_init_done <= done_nxt;

         if (i_flush) begin
            fe_rptr <= '0;
            fe_wptr <= '0;
            fe_cnt  <= '0;
         end else begin
            if (fe_push) fe_wptr <= fe_wptr + FPW'(1);
            if (gnt_fe)  fe_rptr <= fe_rptr + FPW'(1);
            if (fe_push && !gnt_fe)      fe_cnt <= fe_cnt + FCW'(1);
            else if (!fe_push && gnt_fe) fe_cnt <= fe_cnt - FCW'(1);
         end

         if (cmt_push) cmt_wptr <= cmt_wptr + CPW'(1);
         if (gnt_cmt)  cmt_rptr <= cmt_rptr + CPW'(1);
         if (cmt_push && !gnt_cmt)      cmt_cnt <= cmt_cnt + CCW'(1);
         else if (!cmt_push && gnt_cmt) cmt_cnt <= cmt_cnt - CCW'(1);

         if (i_flush || !fe_ne || gnt_fe)
            starve_cnt <= '0;
         else if (gnt_cmt && !starved)
            starve_cnt <= starve_cnt + SCW'(1);
      end
   end

endmodule

// File: tb/tb_xcore_bpu_upd_sched.sv
// Directed bench for xcore_bpu_upd_sched with a 64-entry table (IDXW=6).
module tb_xcore_bpu_upd_sched;
   localparam int IDXW = 6;
   localparam int DW   = 2;
   localparam int NENT = 1 << IDXW;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic            fe_req;
   logic [IDXW-1:0] fe_idx;
   logic [DW-1:0]   fe_data;
   logic            fe_rdy;
   logic            cmt_req;
   logic [IDXW-1:0] cmt_idx;
   logic [DW-1:0]   cmt_data;
   logic            cmt_rdy;
   logic            wr_en;
   logic [IDXW-1:0] wr_idx;
   logic [DW-1:0]   wr_data;
   logic [1:0]      wr_src;
   logic            init_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   xcore_bpu_upd_sched #(
      .IDXW(IDXW), .DW(DW), .INIT_VAL(2'b01),
      .FQ_DEPTH(4), .CQ_DEPTH(4), .STARVE_MAX(3)
   ) dut (
      .i_sys_clk(clk), .i_sys_rst(rst_n), .i_flush(flush),
      .i_fe_req(fe_req), .i_fe_idx(fe_idx), .i_fe_data(fe_data), .o_fe_rdy(fe_rdy),
      .i_cmt_req(cmt_req), .i_cmt_idx(cmt_idx), .i_cmt_data(cmt_data), .o_cmt_rdy(cmt_rdy),
      .o_wr_en(wr_en), .o_wr_idx(wr_idx), .o_wr_data(wr_data), .o_wr_src(wr_src),
      .o_init_done(init_done)
   );

   task automatic test_reset;
      rst_n = 1'b0; flush = 1'b0;
      fe_req = 1'b1; fe_idx = 6'h11; fe_data = 2'b11;
      cmt_req = 1'b1; cmt_idx = 6'h22; cmt_data = 2'b10;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({wr_en, wr_idx, wr_data, wr_src} !== 11'h000) begin
         n_fail++;
         $display("FAIL reset_wr: got en=%b idx=%h data=%b src=%b, want all zero", wr_en, wr_idx, wr_data, wr_src);
      end
      n_checks++;
      if ({init_done, fe_rdy, cmt_rdy} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_status: got done/fe_rdy/cmt_rdy=%b, want 000", {init_done, fe_rdy, cmt_rdy});
      end
   endtask

   task automatic test_sweep;
      rst_n = 1'b1;
      for (int i = 0; i < NENT; i++) begin
         @(negedge clk);
         n_checks++;
         if ({wr_en, wr_idx, wr_data, wr_src, init_done} !== {1'b1, i[5:0], 2'b01, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL sweep_%0d: got en=%b idx=%h data=%b src=%b done=%b, want en=1 idx=%h data=01 src=00 done=0",
                     i, wr_en, wr_idx, wr_data, wr_src, init_done, i[5:0]);
         end
      end
      fe_req = 1'b0; cmt_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({wr_en, init_done, fe_rdy, cmt_rdy} !== 4'b0111) begin
         n_fail++;
         $display("FAIL sweep_done: got en/done/fe_rdy/cmt_rdy=%b, want 0111", {wr_en, init_done, fe_rdy, cmt_rdy});
      end
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_req_ignored: got wr_en=%b, want 0", wr_en);
         end
      end
   endtask

   task automatic test_single_cmt;
      cmt_req = 1'b1; cmt_idx = 6'h2A; cmt_data = 2'b11;
      @(negedge clk);
      cmt_req = 1'b0;
      n_checks++;
      if (wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL single_n1: got wr_en=%b, want 0", wr_en);
      end
      @(negedge clk);
      n_checks++;
      if ({wr_en, wr_idx, wr_data, wr_src} !== {1'b1, 6'h2A, 2'b11, 2'b10}) begin
         n_fail++;
         $display("FAIL single_n2: got en=%b idx=%h data=%b src=%b, want 1 2a 11 10", wr_en, wr_idx, wr_data, wr_src);
      end
      @(negedge clk);
      n_checks++;
      if ({wr_en, wr_idx, wr_data, wr_src} !== {1'b0, 6'h2A, 2'b11, 2'b10}) begin
         n_fail++;
         $display("FAIL single_hold: got en=%b idx=%h data=%b src=%b, want 0 2a 11 10", wr_en, wr_idx, wr_data, wr_src);
      end
   endtask

   task automatic test_same_edge;
      fe_req = 1'b1; fe_idx = 6'h05; fe_data = 2'b10;
      cmt_req = 1'b1; cmt_idx = 6'h07; cmt_data = 2'b00;
      @(negedge clk);
      fe_req = 1'b0; cmt_req = 1'b0;
      n_checks++;
      if (wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL same_n1: got wr_en=%b, want 0", wr_en);
      end
      @(negedge clk);
      n_checks++;
      if ({wr_en, wr_idx, wr_data, wr_src} !== {1'b1, 6'h07, 2'b00, 2'b10}) begin
         n_fail++;
         $display("FAIL same_cmt: got en=%b idx=%h data=%b src=%b, want 1 07 00 10", wr_en, wr_idx, wr_data, wr_src);
      end
      @(negedge clk);
      n_checks++;
      if ({wr_en, wr_idx, wr_data, wr_src} !== {1'b1, 6'h05, 2'b10, 2'b01}) begin
         n_fail++;
         $display("FAIL same_fe: got en=%b idx=%h data=%b src=%b, want 1 05 10 01", wr_en, wr_idx, wr_data, wr_src);
      end
      @(negedge clk);
      n_checks++;
      if (wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL same_idle: got wr_en=%b, want 0", wr_en);
      end
   endtask

   // Commits c0..c4 (idx 10..14) at consecutive edges, one frontend entry (idx 30) at the first.
   task automatic test_starve;
      logic [5:0] exp_idx [6];
      logic [1:0] exp_src [6];
      logic [1:0] exp_dat;
      exp_idx = '{6'h10, 6'h11, 6'h12, 6'h30, 6'h13, 6'h14};
      exp_src = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
      for (int k = 0; k < 8; k++) begin
         cmt_req = (k < 5); cmt_idx = 6'h10 + k[5:0]; cmt_data = 2'b11;
         fe_req = (k == 0); fe_idx = 6'h30; fe_data = 2'b10;
         @(negedge clk);
         if (k >= 1 && k <= 6) begin
            exp_dat = (exp_src[k-1] == 2'b01) ? 2'b10 : 2'b11;
            n_checks++;
            if ({wr_en, wr_idx, wr_data, wr_src} !== {1'b1, exp_idx[k-1], exp_dat, exp_src[k-1]}) begin
               n_fail++;
               $display("FAIL starve_w%0d: got en=%b idx=%h data=%b src=%b, want 1 %h %b %b",
                        k - 1, wr_en, wr_idx, wr_data, wr_src, exp_idx[k-1], exp_dat, exp_src[k-1]);
            end
         end
         if (k == 7) begin
            n_checks++;
            if (wr_en !== 1'b0) begin
               n_fail++;
               $display("FAIL starve_idle: got wr_en=%b, want 0", wr_en);
            end
         end
      end
      fe_req = 1'b0; cmt_req = 1'b0;
   endtask

   // Four frontend pushes fill the queue under commit traffic; a 5th arrives with the flush.
   task automatic test_flush;
      for (int k = 0; k < 10; k++) begin
         cmt_req = (k < 6); cmt_idx = 6'h20 + k[5:0]; cmt_data = 2'b01;
         fe_req = (k < 5); fe_idx = 6'h38 + k[5:0]; fe_data = 2'b10;
         flush = (k == 4);
         @(negedge clk);
         if (k == 3) begin
            n_checks++;
            if (fe_rdy !== 1'b0) begin
               n_fail++;
               $display("FAIL flush_full_rdy: got fe_rdy=%b, want 0", fe_rdy);
            end
         end
         if (k >= 4) begin
            n_checks++;
            if (fe_rdy !== 1'b1) begin
               n_fail++;
               $display("FAIL flush_rdy_%0d: got fe_rdy=%b, want 1", k, fe_rdy);
            end
         end
         if (k >= 1 && k <= 6) begin
            n_checks++;
            if ({wr_en, wr_idx, wr_data, wr_src} !== {1'b1, 6'h20 + 6'(k - 1), 2'b01, 2'b10}) begin
               n_fail++;
               $display("FAIL flush_w%0d: got en=%b idx=%h data=%b src=%b, want 1 %h 01 10",
                        k - 1, wr_en, wr_idx, wr_data, wr_src, 6'h20 + 6'(k - 1));
            end
         end
         if (k >= 7) begin
            n_checks++;
            if (wr_en !== 1'b0) begin
               n_fail++;
               $display("FAIL flush_idle_%0d: got wr_en=%b src=%b, want en 0", k, wr_en, wr_src);
            end
         end
      end
      fe_req = 1'b0; cmt_req = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset_mid;
      cmt_req = 1'b1; cmt_idx = 6'h05; cmt_data = 2'b11;
      @(negedge clk);
      cmt_idx = 6'h06;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({wr_en, wr_idx, wr_data, wr_src, init_done, fe_rdy, cmt_rdy} !== 14'h0) begin
         n_fail++;
         $display("FAIL rst_run: got en=%b idx=%h data=%b src=%b done=%b rdy=%b%b, want all zero",
                  wr_en, wr_idx, wr_data, wr_src, init_done, fe_rdy, cmt_rdy);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if ({wr_en, wr_idx, wr_data, wr_src} !== {1'b1, i[5:0], 2'b01, 2'b00}) begin
            n_fail++;
            $display("FAIL rst_sweep1_%0d: got en=%b idx=%h src=%b, want 1 %h 00", i, wr_en, wr_idx, wr_src, i[5:0]);
         end
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({wr_en, wr_idx, wr_data, wr_src, init_done, fe_rdy, cmt_rdy} !== 14'h0) begin
         n_fail++;
         $display("FAIL rst_sweep: got en=%b idx=%h data=%b src=%b done=%b rdy=%b%b, want all zero",
                  wr_en, wr_idx, wr_data, wr_src, init_done, fe_rdy, cmt_rdy);
      end
      rst_n = 1'b1;
      for (int i = 0; i < NENT; i++) begin
         @(negedge clk);
         n_checks++;
         if ({wr_en, wr_idx, wr_data, wr_src} !== {1'b1, i[5:0], 2'b01, 2'b00}) begin
            n_fail++;
            $display("FAIL rst_sweep2_%0d: got en=%b idx=%h src=%b, want 1 %h 00", i, wr_en, wr_idx, wr_src, i[5:0]);
         end
      end
      cmt_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({wr_en, init_done} !== 2'b01) begin
         n_fail++;
         $display("FAIL rst_done: got en/done=%b, want 01", {wr_en, init_done});
      end
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_lost_cmt: got wr_en=%b idx=%h, want 0", wr_en, wr_idx);
         end
      end
   endtask

   initial begin
      test_reset;
      test_sweep;
      test_single_cmt;
      test_same_edge;
      test_starve;
      test_flush;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
